// File: rtl/xspi_sb_pkg.sv
// Shared definitions for the xSPI 8S link scoreboard: verdict codes, default
// opcodes and the transaction FSM encoding.
package xspi_sb_pkg;

    typedef enum logic [2:0] {
        CODE_OK              = 3'd0,
        CODE_DATA_MISMATCH   = 3'd1,
        CODE_ADDR_MISS       = 3'd2,
        CODE_CRC_RETRY       = 3'd3,
        CODE_RETRY_EXHAUSTED = 3'd4,
        CODE_OVERRUN         = 3'd5,
        CODE_UNKNOWN_CMD     = 3'd6
    } chk_code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2
    } sb_state_e;

    localparam logic [7:0] CMD_WR_DEF = 8'hA5;
    localparam logic [7:0] CMD_RD_DEF = 8'hFF;

endpackage

// File: rtl/xspi_sb_shadow_table.sv
// Associative shadow table: parallel address lookup, lowest-free allocation and
// round-robin replacement once every entry is valid.
module xspi_sb_shadow_table #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 48,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lk_addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    output logic              full
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid_r;
    logic [ADDR_W-1:0] addr_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];
    logic [IDX_W-1:0]  ptr_r;

    logic              hit_s;
    logic [IDX_W-1:0]  hit_idx_s;
    logic              free_any_s;
    logic [IDX_W-1:0]  free_idx_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic              evict_s;

    // Compare every valid entry against the lookup address at once.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_r[i] && (addr_r[i] == lk_addr) && !hit_s) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // Priority encoder: scanning downwards leaves the lowest free index.
    always_comb begin
        free_idx_s = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    assign free_any_s = ~(&valid_r);
    assign evict_s    = wr_en && !hit_s && !free_any_s;

    // Write target: existing entry, else a free slot, else the victim pointer.
    always_comb begin
        if (hit_s) begin
            wr_idx_s = hit_idx_s;
        end else if (free_any_s) begin
            wr_idx_s = free_idx_s;
        end else begin
            wr_idx_s = ptr_r;
        end
    end

    // Valid bits and replacement pointer; the pointer wraps as DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= '0;
            ptr_r   <= '0;
        end else begin
            if (wr_en) begin
                valid_r[wr_idx_s] <= 1'b1;
            end
            if (evict_s) begin
                ptr_r <= ptr_r + IDX_W'(1);
            end
        end
    end

    // Payload storage is qualified by the valid bits and needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            addr_r[wr_idx_s] <= lk_addr;
            data_r[wr_idx_s] <= wr_data;
        end
    end

    assign hit      = hit_s;
    assign hit_data = data_r[hit_idx_s];
    assign full     = ~free_any_s;

endmodule

// File: rtl/xspi_scoreboard.sv
// Synthesizable scoreboard for the xSPI 8S CRC/retransmission link.
// Define XSPI_SB_MISMATCH_MASK_EN to add the per-byte mismatch_mask output.
module xspi_scoreboard
    import xspi_sb_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 48,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = 16,
    parameter logic [7:0]  CMD_WR    = CMD_WR_DEF,
    parameter logic [7:0]  CMD_RD    = CMD_RD_DEF,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              done,
    input  logic [7:0]        command,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              crc_ca_error_slave,
    input  logic              crc_data_error_slave,
    input  logic              crc_data_error_master,
    output logic              chk_valid,
    output logic              chk_pass,
    output logic [2:0]        chk_code,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  crc_err_cnt,
    output logic [CNT_W-1:0]  recovered_cnt,
    output logic              table_full,
    output logic              sticky_fail
`ifdef XSPI_SB_MISMATCH_MASK_EN
    ,
    output logic [DATA_W/8-1:0] mismatch_mask
`endif
);

    localparam int unsigned RUN_W = $clog2(MAX_RETRY + 2);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    sb_state_e         state_r, state_nxt_s;
    logic              capture_s, lookup_s, resp_s;
    logic [7:0]        cmd_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              err_ca_r, err_ds_r, err_dm_r;
    logic              ovr_pend_r, ovr_issue_s;
    logic [RUN_W-1:0]  run_r, run_nxt_s, run_new_s;
    logic [ADDR_W-1:0] raddr_r, raddr_nxt_s;
    logic              hit_s, full_s, tbl_wr_s;
    logic [DATA_W-1:0] hit_data_s;
    chk_code_e         v_code_s;
    logic              v_pass_s, v_fail_s, v_crc_s, v_rec_s;
    logic              is_wr_s, is_rd_s, err_s, same_s;
    logic              pass_ev_s, fail_ev_s, crc_ev_s, rec_ev_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        case (state_r)
            ST_IDLE:   state_nxt_s = done ? ST_LOOKUP : ST_IDLE;
            ST_LOOKUP: state_nxt_s = ST_RESP;
            ST_RESP:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        capture_s = (state_r == ST_IDLE) && done;
        lookup_s  = (state_r == ST_LOOKUP);
        resp_s    = (state_r == ST_RESP);
    end

    // Capture the completed transaction; the data source follows the opcode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_r    <= 8'h00;
            addr_r   <= '0;
            data_r   <= '0;
            err_ca_r <= 1'b0;
            err_ds_r <= 1'b0;
            err_dm_r <= 1'b0;
        end else if (capture_s) begin
            cmd_r    <= command;
            addr_r   <= address;
            data_r   <= (command == CMD_RD) ? rd_data : wr_data;
            err_ca_r <= crc_ca_error_slave;
            err_ds_r <= crc_data_error_slave;
            err_dm_r <= crc_data_error_master;
        end else begin
            cmd_r    <= cmd_r;
        end
    end

    xspi_sb_shadow_table #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .lk_addr  (addr_r),
        .wr_en    (tbl_wr_s),
        .wr_data  (data_r),
        .hit      (hit_s),
        .hit_data (hit_data_s),
        .full     (full_s)
    );

    assign is_wr_s   = (cmd_r == CMD_WR);
    assign is_rd_s   = (cmd_r == CMD_RD);
    assign err_s     = is_wr_s ? (err_ca_r | err_ds_r) : (err_ca_r | err_dm_r);
    assign same_s    = (addr_r == raddr_r);
    assign run_new_s = same_s ? (run_r + RUN_W'(1)) : RUN_W'(1);

    // Verdict and retry bookkeeping for the captured transaction.
    always_comb begin
        v_code_s    = CODE_OK;
        v_pass_s    = 1'b0;
        v_fail_s    = 1'b0;
        v_crc_s     = 1'b0;
        v_rec_s     = 1'b0;
        run_nxt_s   = run_r;
        raddr_nxt_s = raddr_r;
        tbl_wr_s    = 1'b0;
        if (!is_wr_s && !is_rd_s) begin
            v_code_s = CODE_UNKNOWN_CMD;
            v_fail_s = 1'b1;
        end else if (err_s) begin
            v_crc_s     = 1'b1;
            raddr_nxt_s = addr_r;
            if (run_new_s > RUN_W'(MAX_RETRY)) begin
                v_code_s  = CODE_RETRY_EXHAUSTED;
                v_fail_s  = 1'b1;
                run_nxt_s = '0;
            end else begin
                v_code_s  = CODE_CRC_RETRY;
                run_nxt_s = run_new_s;
            end
        end else begin
            if ((run_r != '0) && same_s) begin
                v_rec_s   = 1'b1;
                run_nxt_s = '0;
            end else begin
                run_nxt_s = run_r;
            end
            if (is_wr_s) begin
                tbl_wr_s = lookup_s;
                v_pass_s = 1'b1;
            end else if (!hit_s) begin
                v_code_s = CODE_ADDR_MISS;
                v_fail_s = 1'b1;
            end else if (hit_data_s == data_r) begin
                v_pass_s = 1'b1;
            end else begin
                v_code_s = CODE_DATA_MISMATCH;
                v_fail_s = 1'b1;
            end
        end
    end

    // A dropped done is reported once, in the cycle after RESP.
    assign ovr_issue_s = resp_s && (ovr_pend_r || done);
    assign pass_ev_s   = lookup_s && v_pass_s;
    assign fail_ev_s   = (lookup_s && v_fail_s) || ovr_issue_s;
    assign crc_ev_s    = lookup_s && v_crc_s;
    assign rec_ev_s    = lookup_s && v_rec_s;

    // Overrun pending flag; later overruns merge into the queued one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr_pend_r <= 1'b0;
        end else if (lookup_s && done) begin
            ovr_pend_r <= 1'b1;
        end else if (ovr_issue_s) begin
            ovr_pend_r <= 1'b0;
        end else begin
            ovr_pend_r <= ovr_pend_r;
        end
    end

    // Retry run tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_r   <= '0;
            raddr_r <= '0;
        end else if (lookup_s) begin
            run_r   <= run_nxt_s;
            raddr_r <= raddr_nxt_s;
        end else begin
            run_r   <= run_r;
        end
    end

    // Verdict strobe: transaction verdict on entry to RESP, overrun one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
            chk_code  <= 3'd0;
        end else if (lookup_s) begin
            chk_valid <= 1'b1;
            chk_pass  <= v_pass_s;
            chk_code  <= v_code_s;
        end else if (ovr_issue_s) begin
            chk_valid <= 1'b1;
            chk_pass  <= 1'b0;
            chk_code  <= CODE_OVERRUN;
        end else begin
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
            chk_code  <= 3'd0;
        end
    end

    // Saturating statistics and sticky flag; clear overrides a same-cycle event.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            crc_err_cnt   <= '0;
            recovered_cnt <= '0;
            sticky_fail   <= 1'b0;
        end else begin
            if (pass_ev_s) pass_cnt <= sat_inc(pass_cnt);
            if (fail_ev_s) fail_cnt <= sat_inc(fail_cnt);
            if (crc_ev_s)  crc_err_cnt <= sat_inc(crc_err_cnt);
            if (rec_ev_s)  recovered_cnt <= sat_inc(recovered_cnt);
            if (fail_ev_s) sticky_fail <= 1'b1;
        end
    end

    assign table_full = full_s;

`ifdef XSPI_SB_MISMATCH_MASK_EN
    localparam int unsigned BYTES = DATA_W / 8;
    logic [BYTES-1:0] mask_s;

    // Byte-wise difference between returned and stored data.
    always_comb begin
        mask_s = '0;
        for (int b = 0; b < int'(BYTES); b++) begin
            mask_s[b] = |(hit_data_s[8*b +: 8] ^ data_r[8*b +: 8]);
        end
    end

    // The mask is only meaningful alongside a DATA_MISMATCH verdict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch_mask <= '0;
        end else if (lookup_s && (v_code_s == CODE_DATA_MISMATCH)) begin
            mismatch_mask <= mask_s;
        end else begin
            mismatch_mask <= '0;
        end
    end
`endif

endmodule

// File: doc/xspi_scoreboard.md
Name: xspi_scoreboard

Overview:
- Synthesizable, parametrised scoreboard for the xSPI 8S CRC/retransmission link; replaces the single-entry simulation monitor.
- Keeps an associative shadow table of DEPTH written address/data pairs. Checks every read against the table.
- Classifies CRC-errored attempts as retransmissions and tracks retry runs per address.
- Exposes per-transaction verdicts and saturating statistics counters to the testbench or to on-chip debug registers.

Parameters:
- DATA_W, 64, data width of wr_data/rd_data.
- ADDR_W, 48, address width.
- DEPTH, 8, shadow table entries (power of two, ≥2).
- CNT_W, 16, width of every statistics counter.
- CMD_WR, 8'hA5, write opcode.
- CMD_RD, 8'hFF, read opcode.
- MAX_RETRY, 3, consecutive CRC-errored attempts tolerated per address before exhaustion.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- clear  in  1  synchronous clear of counters and sticky flags; the table is kept.
- done  in  1  single-cycle pulse, transaction complete.
- command  in  8  opcode of the completed transaction.
- address  in  ADDR_W  transaction address.
- wr_data  in  DATA_W  data driven on write.
- rd_data  in  DATA_W  data returned on read.
- crc_ca_error_slave, crc_data_error_slave, crc_data_error_master  in  1 each  CRC error flags; valid with done.
- chk_valid  out  1  one-cycle verdict strobe.
- chk_pass  out  1  verdict; valid with chk_valid.
- chk_code  out  3  0 OK, 1 DATA_MISMATCH, 2 ADDR_MISS, 3 CRC_RETRY, 4 RETRY_EXHAUSTED, 5 OVERRUN, 6 UNKNOWN_CMD.
- pass_cnt, fail_cnt, crc_err_cnt, recovered_cnt  out  CNT_W each  statistics.
- table_full  out  1  all entries valid.
- sticky_fail  out  1  set on any fail verdict.

Behaviour:
- Reset rst_n: synchronous, active-low. All outputs 0. All table valid bits 0. FSM to IDLE. Replacement pointer 0. Retry state cleared.
- FSM IDLE→LOOKUP→RESP→IDLE.
  - IDLE: done=1 captures command, address and data (wr_data or rd_data) plus the CRC flags.
  - LOOKUP: registered table compare, all entries in parallel.
  - RESP: verdict and updates are applied, and chk_valid pulses. Latency is done at cycle T → chk_valid at T+2.
- done in LOOKUP/RESP: transaction dropped, no capture. Produces a separate verdict chk_code=OVERRUN, fail, issued in the cycle after RESP. Only one overrun is queued; further overruns are merged into it.
- Error classification:
  - Write errored = crc_ca_error_slave | crc_data_error_slave.
  - Read errored = crc_ca_error_slave | crc_data_error_master.
- Errored attempt: crc_err_cnt++.
  - If address equals the retry address, retry_run++. Otherwise retry_run=1 and the retry address is set to this address.
  - If retry_run > MAX_RETRY → RETRY_EXHAUSTED (fail), then retry_run=0. Otherwise → CRC_RETRY, not pass, not fail, with no fail_cnt increment.
  - The table is not modified and no read compare is done.
- Clean attempt with retry_run>0 and same address: recovered_cnt++, retry_run=0. Then normal handling.
- Clean write: on hit, the entry data is overwritten. On miss, the lowest-index free entry is allocated. On miss with table full, the entry at the round-robin pointer is replaced and the pointer increments, wrapping DEPTH-1→0. Verdict OK, pass_cnt++.
- Clean read:
  - Hit with data equal → OK, pass_cnt++.
  - Hit with data unequal → DATA_MISMATCH.
  - Miss → ADDR_MISS.
- Any other opcode → UNKNOWN_CMD, fail.
- Every fail verdict: fail_cnt++ and sticky_fail=1.
- Counters saturate at all-ones and do not wrap.
- clear and a counter event in the same cycle: clear wins and the event is lost. clear does not disturb the FSM.
- Reset mid-transaction: the verdict is abandoned with no chk_valid.

Optional Feature:
- XSPI_SB_MISMATCH_MASK_EN defined: adds output mismatch_mask [DATA_W/8-1:0]. It carries the per-byte XOR-nonzero mask of rd_data vs the stored data, registered with chk_valid, and is 0 unless chk_code=DATA_MISMATCH.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package xspi_sb_pkg holds the chk_code enumeration constants, the default CMD_WR/CMD_RD opcodes, and the FSM state encoding.
- Sub-module xspi_sb_shadow_table provides valid/addr/data arrays, parallel hit/index lookup, free-entry priority encoder, round-robin pointer, and write port.

Test Plan:
- Write A=0x10 D=0xDEADBEEF_00000001, then read A=0x10 returning the same → two OK verdicts, each at done+2; pass_cnt=2.
- Read A=0x20 never written → ADDR_MISS, fail_cnt=1, sticky_fail=1. Then clear → counters 0, sticky 0, and entry 0x10 still hits.
- Write 9 distinct addresses with DEPTH=8 → table_full after the 8th. The 9th replaces entry 0. Reading address #1 → ADDR_MISS; reading address #9 → OK.
- Write A=0x30 with crc_data_error_slave=1 twice, then clean → two CRC_RETRY, then OK. crc_err_cnt=2, recovered_cnt=1, fail_cnt=0.
- Four consecutive read errors on A=0x40 (crc_data_error_master) → 3×CRC_RETRY, then RETRY_EXHAUSTED.
- done pulses at T and T+1 → OK at T+2 and OVERRUN at T+3. Read with data 0x…00FF vs stored 0x…0000 → DATA_MISMATCH, mismatch_mask=0x01 (with XSPI_SB_MISMATCH_MASK_EN).
